wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Owns the single register-file write port and shares it between two requesters:
  - the pipeline writeback path, which has priority;
  - the multi-cycle auxiliary unit (multiply/divide result return), which is buffered.
- Aux results are held in a small internal FIFO and drain into pipeline bubbles.
- A starvation counter forces a one-cycle pipeline stall so the aux requester cannot be locked out.
- Sits between the writeback mux output and the register file.

Parameters:
- DEPTH, 2, aux FIFO entries (power of two, >= 2).
- STARVE_LIMIT, 4, consecutive cycles the FIFO head may wait before a stall is forced.
- CNT_W, 3, width of the starvation counter (must be able to hold STARVE_LIMIT).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- wb_valid  input  1  pipeline writeback request (MemWb write-enable).
- wb_reg  input  5  pipeline destination register.
- wb_data  input  32  pipeline write data (writeback mux output).
- aux_valid  input  1  aux unit has a result.
- aux_ready  output  1  FIFO can accept; transfer occurs when aux_valid && aux_ready.
- aux_reg  input  5  aux destination register.
- aux_data  input  32  aux result.
- pipe_stall  output  1  pipeline must freeze MEM/WB and hold wb_* stable.
- rf_we  output  1  register-file write enable.
- rf_waddr  output  5  register-file write address.
- rf_wdata  output  32  register-file write data.
- fifo_count  output  log2(DEPTH)+1  entries currently held, for the hazard unit.

Behaviour:
- Reset (synchronous, active-high; clk and reset as named above): on the clock edge with reset=1:
  - rf_we, rf_waddr, rf_wdata, pipe_stall and the starvation counter go to 0;
  - the FIFO empties, so fifo_count=0;
  - aux_ready=1 from the first cycle after reset.
  - A reset mid-operation drops buffered aux results. The aux unit must reissue them; it is reset by the same signal.
- The write port is registered: a grant decided in cycle N drives rf_we/rf_waddr/rf_wdata in cycle N+1, so latency is 1 cycle for both requesters.
- Register 0: any request with reg==0 is treated as a bubble.
  - Pipeline: no grant.
  - Aux: the entry is accepted and popped without ever asserting rf_we.
- Effective pipeline request: pwb = wb_valid && wb_reg!=0 && !pipe_stall.
- Grant, evaluated each cycle:
  - If pwb=1: grant the pipeline.
  - Else if the FIFO is non-empty: grant the FIFO head and pop it.
  - Else: rf_we=0 next cycle.
- aux_ready = !full. A push and a pop in the same cycle are both allowed when full, and count is unchanged.
- With the FIFO empty, an aux push in cycle N can be granted at the earliest in N+1. There is no bypass from aux_* straight to the port.
- Starvation counter:
  - Increments each cycle that the FIFO is non-empty and the head is not granted.
  - Clears on any FIFO grant or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- When the counter equals STARVE_LIMIT, pipe_stall=1 in the next cycle, for exactly one cycle.
  - During that cycle the FIFO head is granted unconditionally and the counter clears.
  - The pipeline holds wb_*; its request is granted the following cycle. No pipeline write is lost or duplicated.
- Ordering:
  - FIFO entries retire in arrival order.
  - The pipeline and aux never target the same pending register; the hazard unit guarantees this using fifo_count. The arbiter does not check it.
- Simultaneous events: a pipeline write, an aux push and a FIFO pop may all occur in one cycle. Only one write reaches the port per cycle.
- Pointers wrap modulo DEPTH. fifo_count never exceeds DEPTH.

Decomposition:
- Shared package: REG_W=5, DATA_W=32, REG_ZERO=5'd0, and the write-request struct/bundle {valid, reg, data} reused by the pipeline and aux interfaces.
- One sub-module is natural: wb_aux_fifo.
  - Parameterised synchronous FIFO with push/pop, full/empty and count.
  - Instantiated once.
  - Arbitration, starvation control and the output register stay in the top module.

Test Plan:
- Reset: hold reset 2 cycles with wb_valid=1 -> rf_we=0, pipe_stall=0, fifo_count=0, aux_ready=1 throughout; first write appears 1 cycle after reset release.
- Pipeline only: wb_valid=1, wb_reg=8, wb_data=0x1234 at cycle N -> rf_we=1, rf_waddr=8, rf_wdata=0x1234 at N+1. The same stimulus with wb_reg=0 -> rf_we=0.
- Aux into bubble: aux push reg=2, data=0xDEAD with wb_valid=0 -> fifo_count=1, then rf_we=1, rf_waddr=2 one cycle later, fifo_count back to 0.
- Full/backpressure: hold wb_valid=1 (reg 9); push 2 aux results -> aux_ready=0. A third aux_valid is held with no transfer and no data loss.
- Starvation: FIFO head waiting while wb_valid=1 continuously -> pipe_stall=1 for exactly one cycle after 4 waiting cycles. The aux entry is written that cycle and the held pipeline write the next; the total write sequence matches the reference order.
- Reset mid-drain: FIFO holding 2 entries, assert reset -> fifo_count=0 and rf_we=0 on the following cycle; no stale entry is ever written afterwards.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // One write request, used for both the pipeline and the aux path.
  // The destination field is named rd because "reg" is a keyword.
  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // Owner of the write port for the next cycle.
  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_PIPE = 2'd1,
    GRANT_AUX  = 2'd2
  } grant_e;

  // A request only produces a real write when valid and not aimed at x0.
  function automatic logic is_write(input wb_req_t r);
    return r.valid && (r.rd != REG_ZERO);
  endfunction

endpackage

// File: rtl/wb_aux_fifo.sv
// Small synchronous FIFO that buffers aux-unit results until the write
// port has a free slot. Push while full is honoured only alongside a pop.
module wb_aux_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ZERO    = PTR_W'(1'b0);
  localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1'b1);
  localparam logic [PTR_W:0]   COUNT_EMPTY = (PTR_W+1)'(1'b0);
  localparam logic [PTR_W:0]   COUNT_ONE   = (PTR_W+1)'(1'b1);
  localparam logic [PTR_W:0]   COUNT_FULL  = (PTR_W+1)'(DEPTH);

  logic [W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty    = (count_r == COUNT_EMPTY);
  assign full     = (count_r == COUNT_FULL);
  assign count    = count_r;
  assign pop_data = mem_r[rd_ptr_r];

  // Qualify push/pop: never pop empty, never overwrite unless also popping.
  always_comb begin
    do_pop_s  = 1'b0;
    do_push_s = 1'b0;
    if (pop && !empty) begin
      do_pop_s = 1'b1;
    end else begin
      do_pop_s = 1'b0;
    end
    if (push && (!full || do_pop_s)) begin
      do_push_s = 1'b1;
    end else begin
      do_push_s = 1'b0;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= COUNT_EMPTY;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + COUNT_ONE;
        2'b01:   count_r <= count_r - COUNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are don't-care until the pointers reach them.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the pipeline
// writeback (priority) and buffered aux-unit results. Aux results drain into
// pipeline bubbles; a starvation counter forces a one-cycle pipeline stall so
// a waiting aux result is always retired eventually.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wb_valid,
  input  logic [REG_W-1:0]          wb_reg,
  input  logic [DATA_W-1:0]         wb_data,
  input  logic                      aux_valid,
  output logic                      aux_ready,
  input  logic [REG_W-1:0]          aux_reg,
  input  logic [DATA_W-1:0]         aux_data,
  output logic                      pipe_stall,
  output logic                      rf_we,
  output logic [REG_W-1:0]          rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  output logic [$clog2(DEPTH):0]    fifo_count
);

  localparam int ENT_W = REG_W + DATA_W;
  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(1'b0);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]  LIMIT_C   = CNT_W'(STARVE_LIMIT);
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  wb_req_t          pipe_req_s;
  wb_req_t          aux_req_s;
  wb_req_t          head_req_s;
  logic [ENT_W-1:0] head_bits_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic             fifo_push_s;
  logic             fifo_pop_s;
  logic             pwb_s;
  grant_e           grant_s;

  logic             nxt_we_s;
  logic [REG_W-1:0] nxt_waddr_s;
  logic [DATA_W-1:0] nxt_wdata_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             stall_nxt_s;

  logic             rf_we_r;
  logic [REG_W-1:0] rf_waddr_r;
  logic [DATA_W-1:0] rf_wdata_r;
  logic             pipe_stall_r;
  logic [CNT_W-1:0] cnt_r;

  assign pipe_req_s = '{valid: wb_valid,  rd: wb_reg,  data: wb_data};
  assign aux_req_s  = '{valid: aux_valid, rd: aux_reg, data: aux_data};
  assign head_req_s = '{valid: !fifo_empty_s,
                        rd:    head_bits_s[DATA_W +: REG_W],
                        data:  head_bits_s[DATA_W-1:0]};

  // A full FIFO refuses new results; the aux unit holds its request.
  assign aux_ready   = !fifo_full_s;
  assign fifo_push_s = aux_req_s.valid && aux_ready;
  assign fifo_pop_s  = (grant_s == GRANT_AUX);

  wb_aux_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_aux_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push_s),
    .push_data ({aux_req_s.rd, aux_req_s.data}),
    .pop       (fifo_pop_s),
    .pop_data  (head_bits_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count)
  );

  // Pick the port owner: a live pipeline write wins, else the FIFO head.
  // While stalled the pipeline request is masked, so the head wins outright.
  always_comb begin
    pwb_s   = is_write(pipe_req_s) && !pipe_stall_r;
    grant_s = GRANT_NONE;
    if (pwb_s) begin
      grant_s = GRANT_PIPE;
    end else if (!fifo_empty_s) begin
      grant_s = GRANT_AUX;
    end else begin
      grant_s = GRANT_NONE;
    end
  end

  // Form next-cycle write; an x0 head is popped but never written.
  always_comb begin
    nxt_we_s    = 1'b0;
    nxt_waddr_s = REG_ZERO;
    nxt_wdata_s = DATA_ZERO;
    case (grant_s)
      GRANT_PIPE: begin
        nxt_we_s    = 1'b1;
        nxt_waddr_s = pipe_req_s.rd;
        nxt_wdata_s = pipe_req_s.data;
      end
      GRANT_AUX: begin
        nxt_we_s    = is_write(head_req_s);
        nxt_waddr_s = head_req_s.rd;
        nxt_wdata_s = head_req_s.data;
      end
      default: begin
        nxt_we_s    = 1'b0;
        nxt_waddr_s = REG_ZERO;
        nxt_wdata_s = DATA_ZERO;
      end
    endcase
  end

  // Starvation count: cycles the head has waited; the stall is raised in
  // the cycle right after the count reaches the limit, and that stall grants
  // the head, which clears the count and so ends the stall after one cycle.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (fifo_empty_s || (grant_s == GRANT_AUX)) begin
      cnt_nxt_s = CNT_ZERO;
    end else if (cnt_r >= LIMIT_C) begin
      cnt_nxt_s = LIMIT_C;
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end
    stall_nxt_s = (cnt_nxt_s == LIMIT_C);
  end

  // Registered write port, stall flag and starvation counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_r      <= 1'b0;
      rf_waddr_r   <= REG_ZERO;
      rf_wdata_r   <= DATA_ZERO;
      pipe_stall_r <= 1'b0;
      cnt_r        <= CNT_ZERO;
    end else begin
      rf_we_r      <= nxt_we_s;
      rf_waddr_r   <= nxt_waddr_s;
      rf_wdata_r   <= nxt_wdata_s;
      pipe_stall_r <= stall_nxt_s;
      cnt_r        <= cnt_nxt_s;
    end
  end

  assign rf_we      = rf_we_r;
  assign rf_waddr   = rf_waddr_r;
  assign rf_wdata   = rf_wdata_r;
  assign pipe_stall = pipe_stall_r;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomised + directed bench for wb_port_arbiter. A queue-based reference
// model predicts each cycle's port write; predicted writes go into a
// scoreboard queue that a separate monitor drains whenever rf_we is seen.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
  localparam int CNT_W = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_reg;
  logic [31:0] aux_data;
  logic        pipe_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [$clog2(DEPTH):0] fifo_count;

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_reg(aux_reg), .aux_data(aux_data),
    .pipe_stall(pipe_stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  // Reference model state.
  ent_t m_q[$];       // results buffered, oldest first
  ent_t exp_wr[$];    // scoreboard: writes the port must produce, in order
  int   m_wait = 0;   // cycles the oldest buffered result has waited
  bit   m_stall = 0;  // stall expected in the coming cycle
  bit   m_we = 0;     // write expected in the coming cycle
  bit   m_ready = 1;  // aux_ready expected in the coming cycle
  bit   st_prev = 0;  // stall seen in the previous cycle (pipeline freezes)
  bit   aux_hold = 0; // aux request offered but not yet accepted
  bit   mon_en = 0;
  bit   dut_stall_last = 0;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit   pipe_go;
    bit   was_empty;
    bit   head_go;
    ent_t h;
    m_we    = 1'b0;
    head_go = 1'b0;
    if (reset) begin
      m_q.delete();
      m_wait  = 0;
      m_stall = 1'b0;
    end else begin
      was_empty = (m_q.size() == 0);
      pipe_go   = wb_valid && (wb_reg != 5'd0) && !m_stall;
      if (pipe_go) begin
        m_we = 1'b1;
        exp_wr.push_back('{wb_reg, wb_data});
      end else if (!was_empty) begin
        h       = m_q.pop_front();
        head_go = 1'b1;
        if (h.rd != 5'd0) begin
          m_we = 1'b1;
          exp_wr.push_back(h);
        end
      end
      if (aux_valid && m_ready) m_q.push_back('{aux_reg, aux_data});
      if (was_empty || head_go) m_wait = 0;
      else if (m_wait < LIMIT) m_wait++;
      m_stall = (m_wait == LIMIT);
    end
    m_ready = (m_q.size() < DEPTH);
  endtask

  // Drive one cycle. The pipeline keeps wb_* frozen after a stall cycle and
  // the aux unit keeps an unaccepted request, so offered values may be ignored.
  task automatic drive(input bit rst,
                       input bit wv, input logic [4:0] wr, input logic [31:0] wd,
                       input bit av, input logic [4:0] ar, input logic [31:0] ad);
    bit rdy_now;
    @(negedge clk);
    reset = rst;
    if (rst || !st_prev) begin
      wb_valid = wv; wb_reg = wr; wb_data = wd;
    end
    if (rst || !aux_hold) begin
      aux_valid = av; aux_reg = ar; aux_data = ad;
    end
    st_prev  = m_stall;
    rdy_now  = m_ready;
    model_step();
    aux_hold = !rst && aux_valid && !rdy_now;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // Monitor: compare cycle-level outputs and drain the scoreboard on writes.
  always @(posedge clk) begin
    ent_t e;
    #1;
    if (mon_en) begin
      check("rf_we", {31'd0, rf_we}, {31'd0, m_we});
      check("pipe_stall", {31'd0, pipe_stall}, {31'd0, m_stall});
      check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
      check("aux_ready", {31'd0, aux_ready}, {31'd0, m_ready});
      check("stall_one_cycle", {31'd0, pipe_stall && dut_stall_last}, 32'd0);
      dut_stall_last = pipe_stall;
      if (rf_we === 1'b1) begin
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write at %0t",
                   rf_waddr, rf_wdata, $time);
        end else begin
          e = exp_wr.pop_front();
          check("rf_waddr", {27'd0, rf_waddr}, {27'd0, e.rd});
          check("rf_wdata", rf_wdata, e.data);
        end
      end
    end
  end

  initial begin
    // Cycle 0: reset asserted with a pipeline request already present.
    reset = 1'b1;
    wb_valid = 1'b1; wb_reg = 5'd8; wb_data = 32'h0000_1234;
    aux_valid = 1'b0; aux_reg = 5'd0; aux_data = 32'd0;
    model_step();
    mon_en = 1'b1;
    drive(1'b1, 1'b1, 5'd8, 32'h0000_1234, 1'b0, 5'd0, 32'd0);

    // Pipeline write right after release, then an x0 bubble.
    drive(1'b0, 1'b1, 5'd8, 32'h0000_1234, 1'b0, 5'd0, 32'd0);
    drive(1'b0, 1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 32'd0);
    idle(2);

    // Aux result into a bubble.
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'h0000_DEAD);
    idle(3);

    // Backpressure and starvation: pipeline busy on x9, three aux results.
    drive(1'b0, 1'b1, 5'd9, 32'h9000_0001, 1'b1, 5'd3, 32'hA000_0003);
    drive(1'b0, 1'b1, 5'd9, 32'h9000_0002, 1'b1, 5'd4, 32'hA000_0004);
    drive(1'b0, 1'b1, 5'd9, 32'h9000_0003, 1'b1, 5'd5, 32'hA000_0005);
    for (int i = 0; i < 20; i++)
      drive(1'b0, 1'b1, 5'd9, 32'h9100_0000 + 32'(i), 1'b0, 5'd0, 32'd0);
    idle(4);

    // Reset while two results are buffered.
    drive(1'b0, 1'b1, 5'd10, 32'hB000_0001, 1'b1, 5'd11, 32'hC000_0011);
    drive(1'b0, 1'b1, 5'd10, 32'hB000_0002, 1'b1, 5'd12, 32'hC000_0012);
    drive(1'b1, 1'b1, 5'd10, 32'hB000_0003, 1'b0, 5'd0, 32'd0);
    idle(6);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 9) < 7), 5'($urandom_range(0, 31)), $urandom,
            ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 31)), $urandom);
    end
    idle(12);

    @(negedge clk);
    check("scoreboard_drained", 32'(exp_wr.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
